// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmit line between N_REQ byte producers.
// Latches the winning byte with a one-cycle ack and serialises start, 8 data (LSB first), stop.
module uart_tx_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned BIT_CYCLES = 10416
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       data,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] cur_id,
  output logic                     busy,
  output logic                     txd
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(BIT_CYCLES);
  localparam logic [CntW-1:0] BitLast = CntW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  bcnt_q, bcnt_d;
  logic [2:0]       bidx_q, bidx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   cur_id_q, cur_id_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             txd_q, txd_d;

  logic             found;
  logic [IdW-1:0]   win;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = (32'(ptr_q) + k) % N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IdW'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    bidx_d   = bidx_q;
    shreg_d  = shreg_q;
    ptr_d    = ptr_q;
    cur_id_d = cur_id_q;
    ack_d    = '0;
    busy_d   = busy_q;
    txd_d    = txd_q;
    unique case (state_q)
      StIdle: begin
        if (en && found) begin
          shreg_d    = data[8*win +: 8];
          ack_d[win] = 1'b1;
          cur_id_d   = win;
          ptr_d      = IdW'((32'(win) + 1) % N_REQ);
          bcnt_d     = '0;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bcnt_q == BitLast) begin
          state_d = StData;
          txd_d   = shreg_q[0];
          bidx_d  = '0;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      StData: begin
        if (bcnt_q == BitLast) begin
          bcnt_d = '0;
          if (bidx_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            // Next bit is shreg_q[1], i.e. bit 0 after the shift.
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
            bidx_d  = bidx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bcnt_q == BitLast) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      bcnt_q   <= '0;
      bidx_q   <= '0;
      shreg_q  <= '0;
      ptr_q    <= '0;
      cur_id_q <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      bidx_q   <= bidx_d;
      shreg_q  <= shreg_d;
      ptr_q    <= ptr_d;
      cur_id_q <= cur_id_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      txd_q    <= txd_d;
    end
  end

  assign ack    = ack_q;
  assign cur_id = cur_id_q;
  assign busy   = busy_q;
  assign txd    = txd_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: randomized requests checked against a round-robin frame model.
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int BC = 4;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        en   = 1'b0;
  logic [3:0]  req  = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack;
  logic [1:0]  cur_id;
  logic        busy;
  logic        txd;

  int checks    = 0;
  int failures  = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(.N_REQ(N), .BIT_CYCLES(BC)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .req    (req),
    .data   (data),
    .ack    (ack),
    .cur_id (cur_id),
    .busy   (busy),
    .txd    (txd)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  // Reference arbitration: first set bit at or after p, wrapping.
  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic rand_data(input logic [3:0] m);
    for (int k = 0; k < N; k++) if (m[k]) data[8*k +: 8] = 8'($urandom);
  endtask

  // Entered on the negedge where ack is first visible; leaves on the first idle negedge.
  task automatic run_frame(input int id, input bit drop);
    logic [9:0] bits;
    logic [3:0] exp_ack;
    bits = {1'b1, data[8*id +: 8], 1'b0};
    for (int c = 0; c < 10*BC; c++) begin
      exp_ack = (c == 0) ? (4'b0001 << id) : 4'b0000;
      checks++;
      if (txd !== bits[c/BC]) begin
        failures++;
        $display("FAIL txd id=%0d cycle=%0d got=%b exp=%b", id, c, txd, bits[c/BC]);
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_frame id=%0d cycle=%0d got=%b exp=1", id, c, busy);
      end
      checks++;
      if (cur_id !== 2'(id)) begin
        failures++;
        $display("FAIL cur_id cycle=%0d got=%0d exp=%0d", c, cur_id, id);
      end
      checks++;
      if (ack !== exp_ack) begin
        failures++;
        $display("FAIL ack cycle=%0d got=%b exp=%b", c, ack, exp_ack);
      end
      if (c == 0 && drop) begin
        req[id] = 1'b0;
        data[8*id +: 8] = 8'($urandom);
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      failures++;
      $display("FAIL frame_end id=%0d got busy=%b txd=%b exp busy=0 txd=1", id, busy, txd);
    end
  endtask

  task automatic wait_grant(output int id, output int lat, input int limit);
    id  = -1;
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        lat = i;
        break;
      end
    end
    for (int k = 0; k < N; k++) if (ack[k] === 1'b1) id = k;
  endtask

  task automatic serve(input int exp, input bit drop);
    int got, lat;
    wait_grant(got, lat, 20);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL grant got=%0d exp=%0d", got, exp);
    end
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL grant_latency got=%0d exp=1", lat);
    end
    run_frame(exp, drop);
    model_ptr = (exp + 1) % N;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    en   = 1'b1;
    req  = '0;
    rand_data(4'hF);
    repeat (2) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || ack !== 4'b0 || cur_id !== 2'd0) begin
      failures++;
      $display("FAIL reset got txd=%b busy=%b ack=%b cur_id=%0d exp 1 0 0000 0",
               txd, busy, ack, cur_id);
    end
    rstn = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got ack=%b busy=%b exp 0000 0", ack, busy);
    end
  endtask

  task automatic test_single;
    data[7:0] = 8'hA5;
    req = 4'b0001;
    serve(pick(req, model_ptr), 1'b1);
    // ptr should now be 1, so requester 3 beats requester 0.
    req = 4'b1001;
    serve(pick(req, model_ptr), 1'b1);
    serve(pick(req, model_ptr), 1'b1);
  endtask

  task automatic test_simultaneous;
    test_reset();
    req = 4'b1111;
    rand_data(4'hF);
    for (int n = 0; n < N; n++) serve(pick(req, model_ptr), 1'b1);
  endtask

  task automatic test_fairness;
    req = 4'b0101;
    for (int n = 0; n < 4; n++) serve(pick(4'b0101, model_ptr), 1'b0);
    req = '0;
  endtask

  task automatic test_withdraw_en;
    req = 4'b0001;
    rand_data(4'b0011);
    fork
      serve(0, 1'b1);
      begin
        repeat (12) @(negedge clk);
        req[1] = 1'b1;
        en = 1'b0;
        repeat (15) @(negedge clk);
        req[1] = 1'b0;
      end
    join
    req = 4'b0100;
    rand_data(4'b0100);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (ack !== 4'b0 || busy !== 1'b0 || txd !== 1'b1) begin
        failures++;
        $display("FAIL en_gate cycle=%0d got ack=%b busy=%b txd=%b exp 0000 0 1",
                 i, ack, busy, txd);
      end
      @(negedge clk);
    end
    en = 1'b1;
    serve(pick(req, model_ptr), 1'b1);
  endtask

  task automatic test_reset_mid;
    int got, lat;
    logic [9:0] bits;
    req = 4'b0100;
    rand_data(4'b0100);
    bits = {1'b1, data[23:16], 1'b0};
    wait_grant(got, lat, 20);
    checks++;
    if (got !== pick(4'b0100, model_ptr)) begin
      failures++;
      $display("FAIL mid_grant got=%0d exp=2", got);
    end
    for (int c = 0; c < 18; c++) begin
      checks++;
      if (txd !== bits[c/BC]) begin
        failures++;
        $display("FAIL mid_txd cycle=%0d got=%b exp=%b", c, txd, bits[c/BC]);
      end
      if (c == 0) req = '0;
      @(negedge clk);
    end
    rstn = 1'b0;
    req  = 4'b1010;
    rand_data(4'b1010);
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || ack !== 4'b0 || cur_id !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got txd=%b busy=%b ack=%b cur_id=%0d exp 1 0 0000 0",
               txd, busy, ack, cur_id);
    end
    rstn = 1'b1;
    model_ptr = 0;
    serve(pick(req, model_ptr), 1'b1);
    serve(pick(req, model_ptr), 1'b1);
  endtask

  task automatic test_random;
    logic [3:0] extra;
    for (int it = 0; it < 8; it++) begin
      if (req == 4'b0) begin
        req = 4'($urandom_range(1, 15));
        rand_data(req);
      end
      serve(pick(req, model_ptr), 1'b1);
      extra = 4'($urandom_range(0, 15)) & ~req;
      rand_data(extra);
      req = req | extra;
    end
    req = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL random_idle got ack=%b busy=%b exp 0000 0", ack, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_withdraw_en();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one 8N1 UART transmit line between `N_REQ` byte-producing requesters. It contains its own bit-period counter, which generates the baud timing the same way the lab's fixed-constant frequency divider does. It arbitrates byte-level requests, latches the winner's byte with a one-cycle acknowledge, and serialises start bit, 8 data bits (LSB first) and stop bit onto `txd`. It sits between the lab's data sources (keypad, counters, status logic) and the board's UART TX pin.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `BIT_CYCLES`, 10416: clocks per UART bit. The default gives 9600 baud at 100 MHz. Minimum value 2.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rstn` input 1: reset, synchronous, active-low.
- `en` input 1: when low, no new grant is issued. A frame already in progress completes normally.
- `req` input N_REQ: `req[i]` high means requester i has a byte ready. It must be held with stable data until `ack[i]`.
- `data` input 8*N_REQ: byte for requester i is `data[8*i+7:8*i]`.
- `ack` output N_REQ: one-hot, one-cycle pulse. It signals that the byte has been latched and the requester may change `data` or drop `req`.
- `cur_id` output $clog2(N_REQ): index of the requester whose frame is on the line. It is valid while `busy` is high.
- `busy` output 1: high from grant through the last cycle of the stop bit.
- `txd` output 1: serial line; idle level is 1.

## Operation
- **States:** IDLE, START, DATA, STOP. The bit counter `bcnt` counts 0..BIT_CYCLES-1. The bit index `bidx` is 0..7.
- **IDLE:**
  - `txd`=1, `busy`=0.
  - If `en`=1 and `req`≠0, the winner is the first set bit at or after `ptr`, searching upward and wrapping modulo N_REQ.
  - On that edge:
    - `shreg`<=winner byte
    - `ack[w]`<=1
    - `cur_id`<=w
    - `ptr`<=(w+1) mod N_REQ
    - `bcnt`<=0
    - `txd`<=0
    - `busy`<=1
    - state<=START
- **START:** `txd`=0 for BIT_CYCLES clocks. When `bcnt`=BIT_CYCLES-1, go to DATA with `txd`<=`shreg[0]`, `bidx`<=0, `bcnt`<=0.
- **DATA:** each bit is held BIT_CYCLES clocks. At the end of each bit:
  - Shift `shreg` right and drive the next bit.
  - After bit 7 ends, go to STOP with `txd`<=1.
- **STOP:** `txd`=1 for BIT_CYCLES clocks. When `bcnt`=BIT_CYCLES-1, go to IDLE with `busy`<=0.
- **Pointer:** `ptr` resets to 0 and changes only on a grant. A requester that holds `req` continuously is guaranteed service within N_REQ frames.
- **Request handling:**
  - A requester may drop `req` before its `ack` without penalty; it is simply not granted.
  - Requests are not sampled outside IDLE.
  - `data` of non-granted requesters is ignored.
- **Reset:** `rstn`=0 at any point, including mid-frame, forces the following on the next edge:
  - state IDLE
  - `txd`=1, `busy`=0, `ack`=0, `cur_id`=0
  - `ptr`=0, `bcnt`=0, `bidx`=0, `shreg`=0
  - A truncated frame is not resumed.
- **`en` drop:** `en` dropping mid-frame has no effect on that frame.

## Timing
- **Grant latency:** `ack` and the falling edge of `txd` appear on the same clock, one edge after IDLE samples a qualifying `req`.
- **Frame length:** exactly 10×BIT_CYCLES clocks of `busy`=1.
- **Back-to-back frames:** there is one IDLE cycle (`txd`=1) between the stop bit and the next start bit. Each gap is therefore 10×BIT_CYCLES+1 clocks from one start edge to the next.
- **Acknowledge width:** `ack` is high for exactly one cycle per frame, with at most one bit set.
- **`cur_id` stability:** `cur_id` is stable for the whole frame.
- **Signal timing:** `txd` is registered (glitch-free). All outputs change only on clock edges.

## Test plan
- **Single byte:** BIT_CYCLES=4, N_REQ=4; `req`=0001, `data[7:0]`=8'hA5.
  - `ack`=0001 for 1 cycle.
  - `txd` reads 0, 1,0,1,0,0,1,0,1, 1, each held 4 clocks.
  - `busy` is high for 40 clocks, then `ptr`=1.
- **Simultaneous requests:** `req`=1111 held, each requester dropping `req` on its `ack`.
  - Grants occur in order 0,1,2,3.
  - Start edges are 41 clocks apart.
  - Each frame carries its own requester's byte.
- **Fairness:** `req[0]` held permanently and `req[2]` held permanently.
  - Grants alternate 0,2,0,2.
  - `cur_id` matches `ack` for each frame.
- **Withdrawn request and `en` gating:** `req[1]` pulsed during a frame for requester 0 and dropped before the frame ends; later, `en`=0 with `req`=0100.
  - Requester 1 is never acked.
  - No grant is issued until `en`=1, then grant 2 on the next edge.
- **Reset mid-frame:** `rstn`=0 for 1 cycle during DATA bit 3.
  - The next edge gives `txd`=1, `busy`=0, `ptr`=0.
  - A pending `req`=0010 is granted 1 edge after `rstn` returns high.
